// File: rtl/vx_dispatch_pkg.sv
// rtl/vx_dispatch_pkg.sv - shared types, default widths and helpers for the dispatch route arbiter
//
// Purpose : common definitions imported by the dispatch interface, arbiter and top.
// Contents: default batch-id / size widths, default-width request struct,
//           owner-index width helper (never narrower than one bit).
package vx_dispatch_pkg;

    localparam int NB_WIDTH_DEF = 4;
    localparam int NC_WIDTH_DEF = 4;

    // Request payload at the default widths; the top rebuilds the same layout
    // at its own parameter widths.
    typedef struct packed {
        logic [NB_WIDTH_DEF-1:0] id;
        logic [NC_WIDTH_DEF-1:0] size_m1;
        logic [NC_WIDTH_DEF-1:0] core_id;
    } dispatch_req_t;

    // Width of a requester index; a single requester still needs a 1-bit field.
    function automatic int owner_width(input int num_reqs);
        return (num_reqs > 1) ? $clog2(num_reqs) : 1;
    endfunction

endpackage

// File: rtl/vx_dispatch_route_arb_if.sv
// rtl/vx_dispatch_route_arb_if.sv - request/response bus bundle for the dispatch route arbiter
//
// Purpose : groups the per-requester request streams, the downstream dispatch
//           bus and the completion/route signals into one bundle.
// Modports: master - requester/engine side (drives requests, out_req_ready, responses)
//           slave  - arbiter side (accepts requests, drives dispatch bus and routed responses)
interface vx_dispatch_route_arb_if
    import vx_dispatch_pkg::*;
#(
    parameter int NUM_REQS = 4,
    parameter int NB_WIDTH = NB_WIDTH_DEF,
    parameter int NC_WIDTH = NC_WIDTH_DEF
);

    logic [NUM_REQS-1:0]          in_req_valid;
    logic [NUM_REQS*NB_WIDTH-1:0] in_req_id;
    logic [NUM_REQS*NC_WIDTH-1:0] in_req_size_m1;
    logic [NUM_REQS*NC_WIDTH-1:0] in_req_core_id;
    logic [NUM_REQS-1:0]          in_req_ready;

    logic                         out_req_valid;
    logic                         out_req_ready;
    logic [NB_WIDTH-1:0]          out_req_id;
    logic [NC_WIDTH-1:0]          out_req_size_m1;
    logic [NC_WIDTH-1:0]          out_req_core_id;

    logic                         out_rsp_valid;
    logic [NB_WIDTH-1:0]          out_rsp_id;
    logic [NUM_REQS-1:0]          in_rsp_valid;
    logic [NB_WIDTH-1:0]          in_rsp_id;
    logic                         rsp_drop;
    logic [NB_WIDTH:0]            pending_cnt;

    modport master (
        output in_req_valid, in_req_id, in_req_size_m1, in_req_core_id,
        input  in_req_ready,
        input  out_req_valid, out_req_id, out_req_size_m1, out_req_core_id,
        output out_req_ready,
        output out_rsp_valid, out_rsp_id,
        input  in_rsp_valid, in_rsp_id, rsp_drop, pending_cnt
    );

    modport slave (
        input  in_req_valid, in_req_id, in_req_size_m1, in_req_core_id,
        output in_req_ready,
        output out_req_valid, out_req_id, out_req_size_m1, out_req_core_id,
        input  out_req_ready,
        input  out_rsp_valid, out_rsp_id,
        output in_rsp_valid, in_rsp_id, rsp_drop, pending_cnt
    );

endinterface

// File: rtl/vx_dispatch_rr_arb.sv
// rtl/vx_dispatch_rr_arb.sv - masked round-robin arbiter with internal priority pointer
//
// Purpose : picks the first masked-in request at or after the priority pointer.
// Ports   : clk, reset      - clock, async active-high reset
//           req_mask_i      - eligible requesters
//           enable_i        - grant is actually taken this cycle (advances pointer)
//           grant_o         - one-hot candidate (valid regardless of enable_i)
//           grant_idx_o     - index of the candidate
//           grant_valid_o   - some requester is masked in
module vx_dispatch_rr_arb
    import vx_dispatch_pkg::*;
#(
    parameter int NUM_REQS = 4,
    parameter int IDX_W    = owner_width(NUM_REQS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_REQS-1:0] req_mask_i,
    input  logic                enable_i,
    output logic [NUM_REQS-1:0] grant_o,
    output logic [IDX_W-1:0]    grant_idx_o,
    output logic                grant_valid_o
);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;
    int               cand;

    // Scan NUM_REQS positions starting from the pointer, wrapping at NUM_REQS
    // so non-power-of-two requester counts never reach an unused index.
    always_comb begin
        grant_o       = '0;
        grant_idx_o   = '0;
        grant_valid_o = 1'b0;
        cand          = 0;
        for (int k = 0; k < NUM_REQS; k++) begin
            cand = int'(ptr_q) + k;
            if (cand >= NUM_REQS) begin
                cand = cand - NUM_REQS;
            end
            if (!grant_valid_o && req_mask_i[cand]) begin
                grant_valid_o = 1'b1;
                grant_o[cand] = 1'b1;
                grant_idx_o   = IDX_W'(cand);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (enable_i && grant_valid_o) begin
            ptr_d = (grant_idx_o == IDX_W'(NUM_REQS - 1)) ? '0 : grant_idx_o + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/vx_dispatch_route_arb.sv
// rtl/vx_dispatch_route_arb.sv - N-to-1 dispatch arbiter with id tracking and response routing
//
// Purpose : merges NUM_REQS request streams onto one dispatch bus with
//           round-robin fairness, records the owner of every accepted batch id
//           and routes each completion back to that owner only.
// Ports   : clk   - clock
//           reset - async active-high reset
//           bus   - slave side of vx_dispatch_route_arb_if (request streams,
//                   dispatch bus, completion input, routed completion, rsp_drop,
//                   pending_cnt)
module vx_dispatch_route_arb
    import vx_dispatch_pkg::*;
#(
    parameter int NUM_REQS  = 4,
    parameter int NB_WIDTH  = NB_WIDTH_DEF,
    parameter int NC_WIDTH  = NC_WIDTH_DEF,
    parameter int OUT_BUF   = 1,
    parameter int RSP_BCAST = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    vx_dispatch_route_arb_if.slave  bus
);

    localparam int OW    = owner_width(NUM_REQS);
    localparam int DEPTH = 1 << NB_WIDTH;

    typedef struct packed {
        logic [NB_WIDTH-1:0] id;
        logic [NC_WIDTH-1:0] size_m1;
        logic [NC_WIDTH-1:0] core_id;
    } req_t;

    // Tracking table and response register
    logic [DEPTH-1:0]    busy_q;
    logic [OW-1:0]       owner_q [DEPTH];
    logic [NB_WIDTH:0]   pending_q;
    logic [NB_WIDTH:0]   pending_d;
    logic                rsp_v_q;
    logic [NB_WIDTH-1:0] rsp_id_q;

    req_t                req_in [NUM_REQS];
    logic [NUM_REQS-1:0] eligible;
    logic [NUM_REQS-1:0] grant;
    logic [OW-1:0]       grant_idx;
    logic                grant_any;
    logic                cap;
    logic                arb_en;
    logic                accept;
    req_t                acc_req;
    logic                rsp_hit;
    logic [NUM_REQS-1:0] rsp_vec;

    // A requester whose id is still outstanding is masked out so it cannot
    // block others behind it.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            req_in[i].id      = bus.in_req_id[i*NB_WIDTH +: NB_WIDTH];
            req_in[i].size_m1 = bus.in_req_size_m1[i*NC_WIDTH +: NC_WIDTH];
            req_in[i].core_id = bus.in_req_core_id[i*NC_WIDTH +: NC_WIDTH];
            eligible[i]       = bus.in_req_valid[i] && !busy_q[req_in[i].id];
        end
    end

    vx_dispatch_rr_arb #(
        .NUM_REQS (NUM_REQS),
        .IDX_W    (OW)
    ) u_rr_arb (
        .clk           (clk),
        .reset         (reset),
        .req_mask_i    (eligible),
        .enable_i      (arb_en),
        .grant_o       (grant),
        .grant_idx_o   (grant_idx),
        .grant_valid_o (grant_any)
    );

    // Two eligible requesters with the same id cannot both win: the grant is
    // one-hot, and the loser sees the busy bit next cycle.
    assign arb_en           = cap & ~reset;
    assign accept           = grant_any & arb_en;
    assign acc_req          = req_in[grant_idx];
    assign bus.in_req_ready = grant & {NUM_REQS{arb_en}};

    // Retire uses the pre-update busy bit, so an id accepted this cycle can
    // never be retired by a response arriving in the same cycle.
    assign rsp_hit      = rsp_v_q &  busy_q[rsp_id_q];
    assign bus.rsp_drop = rsp_v_q & ~busy_q[rsp_id_q];

    always_comb begin
        rsp_vec = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            rsp_vec[i] = rsp_hit && ((RSP_BCAST != 0) || (owner_q[rsp_id_q] == OW'(i)));
        end
    end

    assign bus.in_rsp_valid = rsp_vec;
    assign bus.in_rsp_id    = rsp_id_q;
    assign bus.pending_cnt  = pending_q;

    always_comb begin
        pending_d = pending_q;
        case ({accept, rsp_hit})
            2'b10:   pending_d = pending_q + 1'b1;
            2'b01:   pending_d = pending_q - 1'b1;
            default: pending_d = pending_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q    <= '0;
            pending_q <= '0;
            rsp_v_q   <= 1'b0;
            rsp_id_q  <= '0;
        end else begin
            rsp_v_q   <= bus.out_rsp_valid;
            rsp_id_q  <= bus.out_rsp_id;
            pending_q <= pending_d;
            if (rsp_hit) begin
                busy_q[rsp_id_q] <= 1'b0;
            end
            if (accept) begin
                busy_q[acc_req.id] <= 1'b1;
            end
        end
    end

    // Owner entries are only meaningful while the busy bit is set.
    always_ff @(posedge clk) begin
        if (accept) begin
            owner_q[acc_req.id] <= grant_idx;
        end
    end

    if (OUT_BUF != 0) begin : g_buf
        // Two-slot elastic stage: slot0 is always the head. Capacity depends
        // only on slot1 occupancy, so in_req_ready never sees out_req_ready.
        req_t slot0_q;
        req_t slot1_q;
        logic v0_q;
        logic v1_q;
        logic pop;

        assign cap = ~v1_q;
        assign pop = v0_q & bus.out_req_ready;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                v0_q    <= 1'b0;
                v1_q    <= 1'b0;
                slot0_q <= '0;
                slot1_q <= '0;
            end else if (pop) begin
                if (v1_q) begin
                    slot0_q <= slot1_q;
                    v1_q    <= 1'b0;
                end else if (accept) begin
                    slot0_q <= acc_req;
                end else begin
                    v0_q    <= 1'b0;
                end
            end else if (accept) begin
                if (!v0_q) begin
                    slot0_q <= acc_req;
                    v0_q    <= 1'b1;
                end else begin
                    slot1_q <= acc_req;
                    v1_q    <= 1'b1;
                end
            end
        end

        assign bus.out_req_valid   = v0_q;
        assign bus.out_req_id      = slot0_q.id;
        assign bus.out_req_size_m1 = slot0_q.size_m1;
        assign bus.out_req_core_id = slot0_q.core_id;
    end else begin : g_comb
        // Valid reflects the current candidate independently of out_req_ready.
        assign cap                 = bus.out_req_ready;
        assign bus.out_req_valid   = grant_any & ~reset;
        assign bus.out_req_id      = acc_req.id;
        assign bus.out_req_size_m1 = acc_req.size_m1;
        assign bus.out_req_core_id = acc_req.core_id;
    end

endmodule

// File: tb/tb_vx_dispatch_route_arb.sv
// tb/tb_vx_dispatch_route_arb.sv - directed self-checking bench for vx_dispatch_route_arb
module tb_vx_dispatch_route_arb;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    vx_dispatch_route_arb_if #(.NUM_REQS(4), .NB_WIDTH(4), .NC_WIDTH(4)) m_if ();
    vx_dispatch_route_arb_if #(.NUM_REQS(4), .NB_WIDTH(4), .NC_WIDTH(4)) b_if ();

    vx_dispatch_route_arb #(
        .NUM_REQS(4), .NB_WIDTH(4), .NC_WIDTH(4), .OUT_BUF(1), .RSP_BCAST(0)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (m_if)
    );

    vx_dispatch_route_arb #(
        .NUM_REQS(4), .NB_WIDTH(4), .NC_WIDTH(4), .OUT_BUF(0), .RSP_BCAST(1)
    ) u_bc (
        .clk   (clk),
        .reset (reset),
        .bus   (b_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic v, input logic [3:0] id,
                           input logic [3:0] sz, input logic [3:0] core);
        m_if.in_req_valid[k]            = v;
        m_if.in_req_id[k*4 +: 4]        = id;
        m_if.in_req_size_m1[k*4 +: 4]   = sz;
        m_if.in_req_core_id[k*4 +: 4]   = core;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b1;
        m_if.in_req_valid = '0; m_if.in_req_id = '0; m_if.in_req_size_m1 = '0;
        m_if.in_req_core_id = '0; m_if.out_req_ready = 1'b0;
        m_if.out_rsp_valid = 1'b0; m_if.out_rsp_id = '0;
        b_if.in_req_valid = '0; b_if.in_req_id = '0; b_if.in_req_size_m1 = '0;
        b_if.in_req_core_id = '0; b_if.out_req_ready = 1'b0;
        b_if.out_rsp_valid = 1'b0; b_if.out_rsp_id = '0;

        // Reset values
        tick(); tick();
        chk("rst_pending", m_if.pending_cnt, 0);
        chk("rst_out_valid", m_if.out_req_valid, 0);
        chk("rst_in_rsp_valid", m_if.in_rsp_valid, 0);
        chk("rst_rsp_drop", m_if.rsp_drop, 0);
        chk("rst_in_req_ready", m_if.in_req_ready, 0);
        reset = 1'b0;
        tick();

        // Idle response to a non-outstanding id
        m_if.out_rsp_valid = 1'b1; m_if.out_rsp_id = 4'd3;
        tick();
        m_if.out_rsp_valid = 1'b0;
        chk("idle_drop", m_if.rsp_drop, 1);
        chk("idle_no_route", m_if.in_rsp_valid, 0);
        tick();
        chk("idle_drop_pulse", m_if.rsp_drop, 0);

        // Round robin 0,1,2,3 through the elastic buffer
        m_if.out_req_ready = 1'b1;
        for (int k = 0; k < 4; k++) set_req(k, 1'b1, 4'(k), 4'(k + 1), 4'(k + 8));
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("rr_ready", m_if.in_req_ready, 32'(1 << k));
            tick();
            m_if.in_req_valid[k] = 1'b0;
            #1;
            chk("rr_out_valid", m_if.out_req_valid, 1);
            chk("rr_out_id", m_if.out_req_id, k);
            chk("rr_out_core", m_if.out_req_core_id, k + 8);
            chk("rr_out_size", m_if.out_req_size_m1, k + 1);
        end
        chk("rr_pending4", m_if.pending_cnt, 4);
        tick();
        chk("rr_drained", m_if.out_req_valid, 0);

        // Route each response to its owner
        for (int k = 0; k < 4; k++) begin
            m_if.out_rsp_valid = 1'b1; m_if.out_rsp_id = 4'(k);
            tick();
            chk("route_vec", m_if.in_rsp_valid, 32'(1 << k));
            chk("route_id", m_if.in_rsp_id, k);
            chk("route_nodrop", m_if.rsp_drop, 0);
        end
        m_if.out_rsp_valid = 1'b0;
        tick();
        chk("route_pending0", m_if.pending_cnt, 0);
        chk("route_idle", m_if.in_rsp_valid, 0);

        // Id collision: req0/req1 share id 5, req2 carries id 6
        set_req(0, 1'b1, 4'd5, 4'd0, 4'd1);
        set_req(1, 1'b1, 4'd5, 4'd0, 4'd2);
        set_req(2, 1'b1, 4'd6, 4'd0, 4'd3);
        #1;
        chk("col_first", m_if.in_req_ready, 4'b0001);
        tick();
        m_if.in_req_valid[0] = 1'b0;
        #1;
        chk("col_skip_busy", m_if.in_req_ready, 4'b0100);
        tick();
        m_if.in_req_valid[2] = 1'b0;
        #1;
        chk("col_stall", m_if.in_req_ready, 4'b0000);
        chk("col_pending2", m_if.pending_cnt, 2);
        m_if.out_rsp_valid = 1'b1; m_if.out_rsp_id = 4'd5;
        tick();
        m_if.out_rsp_valid = 1'b0;
        #1;
        chk("col_rsp_vec", m_if.in_rsp_valid, 4'b0001);
        chk("col_rsp_id", m_if.in_rsp_id, 5);
        chk("col_still_busy", m_if.in_req_ready, 4'b0000);
        tick();
        chk("col_reaccept", m_if.in_req_ready, 4'b0010);
        chk("col_pending1", m_if.pending_cnt, 1);
        tick();
        m_if.in_req_valid[1] = 1'b0;
        chk("col_pending2b", m_if.pending_cnt, 2);
        m_if.out_rsp_valid = 1'b1; m_if.out_rsp_id = 4'd6;
        tick();
        chk("col_rsp6", m_if.in_rsp_valid, 4'b0100);
        m_if.out_rsp_id = 4'd5;
        tick();
        chk("col_rsp5_new_owner", m_if.in_rsp_valid, 4'b0010);
        m_if.out_rsp_valid = 1'b0;
        tick();
        chk("col_pending0", m_if.pending_cnt, 0);

        // Backpressure: pointer now at 2, so req2 then req3 fill the buffer
        m_if.out_req_ready = 1'b0;
        for (int k = 0; k < 4; k++) set_req(k, 1'b1, 4'(k + 8), 4'(k), 4'(k));
        #1;
        chk("bp_acc1", m_if.in_req_ready, 4'b0100);
        tick();
        m_if.in_req_valid[2] = 1'b0;
        #1;
        chk("bp_acc2", m_if.in_req_ready, 4'b1000);
        tick();
        m_if.in_req_valid[3] = 1'b0;
        #1;
        chk("bp_full", m_if.in_req_ready, 4'b0000);
        chk("bp_head", m_if.out_req_id, 10);
        chk("bp_pending2", m_if.pending_cnt, 2);
        tick();
        chk("bp_full_hold", m_if.in_req_ready, 4'b0000);
        chk("bp_head_stable", m_if.out_req_id, 10);
        chk("bp_valid_held", m_if.out_req_valid, 1);
        m_if.out_req_ready = 1'b1;
        #1;
        chk("bp_ready_decoupled", m_if.in_req_ready, 4'b0000);
        tick();
        chk("bp_second", m_if.out_req_id, 11);
        chk("bp_reopen", m_if.in_req_ready, 4'b0001);
        m_if.in_req_valid = '0;
        tick();
        chk("bp_empty", m_if.out_req_valid, 0);
        m_if.out_rsp_valid = 1'b1; m_if.out_rsp_id = 4'd10;
        tick();
        chk("bp_rsp10", m_if.in_rsp_valid, 4'b0100);
        m_if.out_rsp_id = 4'd11;
        tick();
        chk("bp_rsp11", m_if.in_rsp_valid, 4'b1000);
        m_if.out_rsp_valid = 1'b0;
        tick();
        chk("bp_pending0", m_if.pending_cnt, 0);

        // Async reset with three ids pending
        for (int k = 0; k < 3; k++) set_req(k, 1'b1, 4'(k + 1), 4'd0, 4'd0);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("ar_ready", m_if.in_req_ready, 32'(1 << k));
            tick();
            m_if.in_req_valid[k] = 1'b0;
        end
        chk("ar_pending3", m_if.pending_cnt, 3);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_pending_cleared", m_if.pending_cnt, 0);
        chk("ar_out_valid", m_if.out_req_valid, 0);
        #2;
        reset = 1'b0;
        m_if.out_rsp_valid = 1'b1; m_if.out_rsp_id = 4'd2;
        tick();
        m_if.out_rsp_valid = 1'b0;
        chk("ar_drop", m_if.rsp_drop, 1);
        chk("ar_no_route", m_if.in_rsp_valid, 0);
        chk("ar_pending_still0", m_if.pending_cnt, 0);

        // Broadcast instance, combinational output
        b_if.in_req_valid[3] = 1'b1;
        b_if.in_req_id[12 +: 4] = 4'd2;
        b_if.in_req_size_m1[12 +: 4] = 4'd5;
        b_if.in_req_core_id[12 +: 4] = 4'd7;
        #1;
        chk("bc_comb_valid", b_if.out_req_valid, 1);
        chk("bc_comb_id", b_if.out_req_id, 2);
        chk("bc_comb_size", b_if.out_req_size_m1, 5);
        chk("bc_not_ready", b_if.in_req_ready, 4'b0000);
        b_if.out_req_ready = 1'b1;
        #1;
        chk("bc_ready_follows", b_if.in_req_ready, 4'b1000);
        tick();
        b_if.in_req_valid = '0;
        chk("bc_pending1", b_if.pending_cnt, 1);
        b_if.out_rsp_valid = 1'b1; b_if.out_rsp_id = 4'd2;
        tick();
        b_if.out_rsp_valid = 1'b0;
        chk("bc_rsp_vec", b_if.in_rsp_valid, 4'b1111);
        chk("bc_rsp_id", b_if.in_rsp_id, 2);
        tick();
        chk("bc_pending0", b_if.pending_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
